sica_seq_ctrl: RTL and testbench
================================

Name: sica_seq_ctrl

Overview:
Central sequencer for the Simplex-FastICA core.
- Captures the serial, channel-major input stream (DIM*SAMPLES words) into the sample memory by generating write addresses.
- On sica_start, runs the per-component FastICA loop: SAMPLES-long read sweeps, one weight update, then a convergence check.
- Stops a component on convergence or at MAX_ITERATIONS, then raises sica_complete after all DIM components.

Parameters:
DATA_WIDTH, 32, width of input samples
SAMPLES, 1024, samples per channel window
DIM, 5, number of channels/components
MAX_ITERATIONS, 500, iteration cap per component
LOGM, 10, sample index width; log2(SAMPLES)
Derived: AW = $clog2(DIM*SAMPLES), CW = $clog2(DIM), IW = $clog2(MAX_ITERATIONS+1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
load_data  in  1  load window open
serial_z_valid  in  1  serial_z_in qualifier
serial_z_in  in  DATA_WIDTH  whitened sample, channel-major order
sica_start  in  1  start pulse
mem_we  out  1  sample memory write enable
mem_waddr  out  AW  write address = chan*SAMPLES + sample
mem_wdata  out  DATA_WIDTH  registered serial_z_in
rd_en  out  1  sample read strobe for the datapath
rd_sample  out  LOGM  sample index being read
comp_idx  out  CW  component currently being estimated
acc_clear  out  1  one-cycle accumulator clear before each sweep
upd_start  out  1  one-cycle request for the weight update (CORDIC/normalise)
upd_done  in  1  update finished; converged is valid in the same cycle
converged  in  1  convergence flag from the datapath
iter_count  out  IW  iterations completed on comp_idx
load_full  out  1  all DIM*SAMPLES words captured
sica_busy  out  1  high from start acceptance until DONE
sica_complete  out  1  level output, high in DONE
err_overrun  out  1  sticky; valid received while memory full

Behaviour:
- Reset: every output is 0; state is IDLE; all counters are 0.
- Load path runs in IDLE/LOAD only:
  - load_data & serial_z_valid in the same cycle: mem_we=1 with mem_waddr=wcnt and mem_wdata=serial_z_in, all registered (1-cycle latency); wcnt increments.
  - When wcnt reaches DIM*SAMPLES: load_full=1 and wcnt stops. A further valid sets err_overrun and produces no write.
  - load_data falling before the memory is full: wcnt resets to 0 and load_full stays 0 (partial load is discarded).
  - A new load_data rising edge in IDLE or DONE clears load_full, wcnt and err_overrun.
- sica_start: ignored unless load_full=1 and state is IDLE or DONE. Accepting it clears sica_complete, comp_idx and iter_count, then enters CLR.
- FSM: IDLE -> CLR -> SWEEP -> UPD -> WAIT -> (CLR | NEXT) -> DONE.
  - CLR: acc_clear=1 for 1 cycle.
  - SWEEP: rd_en=1 for exactly SAMPLES consecutive cycles; rd_sample runs 0..SAMPLES-1 with no gaps.
  - UPD: upd_start=1 for 1 cycle.
  - WAIT: hold until upd_done. On upd_done, iter_count increments.
    - If converged=1 or iter_count+1 == MAX_ITERATIONS -> NEXT.
    - Otherwise -> CLR.
    - upd_done arriving outside WAIT is ignored.
  - NEXT (1 cycle): if comp_idx == DIM-1 -> DONE; else comp_idx increments, iter_count clears -> CLR.
  - DONE: sica_complete=1 and sica_busy=0; comp_idx and iter_count hold their final values.
- Minimum iteration length: 1 + SAMPLES + 1 + (cycles until upd_done) + 1 cycles.
- Load path is inactive while sica_busy: load_data and serial_z_valid are ignored with no write and no err_overrun.
- Asynchronous reset mid-run returns to IDLE and clears load_full, so a full reload is required.

Optional Feature:
SICA_TIMEOUT_EN
- Defined: a 16-bit watchdog counts cycles in WAIT.
  - Reaching 65535 without upd_done sets sticky output err_timeout and goes to DONE.
  - err_timeout clears on the next accepted sica_start or on reset.
- Undefined: no watchdog; WAIT holds indefinitely; err_timeout is tied to 0.

Test Plan:
Bench configuration: DIM=2, SAMPLES=8, LOGM=3, MAX_ITERATIONS=3.
1. Stream 16 valid words 100..115 under load_data -> mem_waddr 0..15 with matching mem_wdata, one cycle late; load_full=1 after the 16th word; err_overrun=0.
2. After step 1, send a 17th valid word -> no write; err_overrun=1; load_full stays 1.
3. Drop load_data after 5 words, then assert sica_start -> load_full=0 and FSM stays IDLE (sica_busy=0).
4. Full load, sica_start; upd_done returned 2 cycles after upd_start with converged=0 -> 3 sweeps of 8 rd_en cycles per component; iter_count reaches 3 per component; sica_complete after comp_idx=1.
5. Full load, sica_start; converged=1 on the first upd_done of each component -> one sweep per component; iter_count=1 in DONE; 2 upd_start pulses in total.
6. Assert reset during SWEEP at rd_sample=4 -> all outputs 0 immediately; subsequent sica_start ignored until a reload completes.

Source files
------------

// File: rtl/sica_seq_ctrl.sv
// Central sequencer for the Simplex-FastICA core: sample-memory load addressing and
// the per-component sweep/update/convergence loop. Optional watchdog: SICA_TIMEOUT_EN.
module sica_seq_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int SAMPLES        = 1024,
  parameter int DIM            = 5,
  parameter int MAX_ITERATIONS = 500,
  parameter int LOGM           = 10,
  localparam int AW = $clog2(DIM*SAMPLES),
  localparam int CW = $clog2(DIM),
  localparam int IW = $clog2(MAX_ITERATIONS+1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_data,
  input  logic                  serial_z_valid,
  input  logic [DATA_WIDTH-1:0] serial_z_in,
  input  logic                  sica_start,
  output logic                  mem_we,
  output logic [AW-1:0]         mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  rd_en,
  output logic [LOGM-1:0]       rd_sample,
  output logic [CW-1:0]         comp_idx,
  output logic                  acc_clear,
  output logic                  upd_start,
  input  logic                  upd_done,
  input  logic                  converged,
  output logic [IW-1:0]         iter_count,
  output logic                  load_full,
  output logic                  sica_busy,
  output logic                  sica_complete,
  output logic                  err_overrun,
  output logic                  err_timeout,
  output logic [2:0]            state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_SWEEP = 3'd2,
    S_UPD   = 3'd3,
    S_WAIT  = 3'd4,
    S_NEXT  = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam logic [AW:0]     TOTAL_W   = (AW+1)'(DIM*SAMPLES);
  localparam logic [LOGM-1:0] LAST_SMP  = LOGM'(SAMPLES-1);
  localparam logic [CW-1:0]   LAST_COMP = CW'(DIM-1);
  localparam logic [IW-1:0]   MAX_IT    = IW'(MAX_ITERATIONS);

  state_t      state, state_nx;
  logic        load_active, start_ok, timeout;
  logic        load_q, load_rise, full_eff, do_write;
  logic [AW:0] wcnt, wbase, wnext;
  logic [IW-1:0] iter_inc;

  // Handshake: upd_start is a one-cycle request; upd_done is honoured only in WAIT,
  // and converged is sampled in that same cycle.
  assign load_active = (state == S_IDLE) || (state == S_DONE);
  assign start_ok    = sica_start && load_full && load_active;
  assign iter_inc    = iter_count + 1'b1;

  // A rising load_data restarts the window in the same cycle it is seen.
  assign load_rise = load_data && !load_q;
  assign wbase     = load_rise ? '0 : wcnt;
  assign full_eff  = load_rise ? 1'b0 : load_full;
  assign wnext     = wbase + 1'b1;
  assign do_write  = load_active && load_data && serial_z_valid && !full_eff;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_q      <= 1'b0;
      wcnt        <= '0;
      load_full   <= 1'b0;
      err_overrun <= 1'b0;
      mem_we      <= 1'b0;
      mem_waddr   <= '0;
      mem_wdata   <= '0;
    end else begin
      load_q <= load_data;
      mem_we <= do_write;
      if (do_write) begin
        mem_waddr <= wbase[AW-1:0];
        mem_wdata <= serial_z_in;
      end
      if (load_active) begin
        if (load_rise) begin
          wcnt        <= '0;
          load_full   <= 1'b0;
          err_overrun <= 1'b0;
        end
        if (do_write) begin
          wcnt      <= wnext;
          load_full <= (wnext == TOTAL_W);
        end else if (!load_data && !load_full) begin
          wcnt <= '0;
        end
        if (serial_z_valid && full_eff) err_overrun <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: if (start_ok) state_nx = S_CLR;
      S_CLR:          state_nx = S_SWEEP;
      S_SWEEP:        if (rd_sample == LAST_SMP) state_nx = S_UPD;
      S_UPD:          state_nx = S_WAIT;
      S_WAIT: begin
        if (upd_done) state_nx = (converged || iter_inc == MAX_IT) ? S_NEXT : S_CLR;
        else if (timeout) state_nx = S_DONE;
      end
      S_NEXT:         state_nx = (comp_idx == LAST_COMP) ? S_DONE : S_CLR;
      default:        state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      rd_sample  <= '0;
      comp_idx   <= '0;
      iter_count <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE, S_DONE: if (start_ok) begin
          comp_idx   <= '0;
          iter_count <= '0;
        end
        S_CLR:   rd_sample <= '0;
        S_SWEEP: rd_sample <= rd_sample + 1'b1;
        S_WAIT:  if (upd_done) iter_count <= iter_inc;
        S_NEXT:  if (comp_idx != LAST_COMP) begin
          comp_idx   <= comp_idx + 1'b1;
          iter_count <= '0;
        end
        default: ;
      endcase
    end
  end

  assign acc_clear     = (state == S_CLR);
  assign rd_en         = (state == S_SWEEP);
  assign upd_start     = (state == S_UPD);
  assign sica_busy     = !load_active;
  assign sica_complete = (state == S_DONE);
  assign state_dbg     = state;

`ifdef SICA_TIMEOUT_EN
  logic [15:0] wd_cnt;
  logic        err_to_q;

  assign timeout     = (state == S_WAIT) && !upd_done && (wd_cnt == 16'hFFFF);
  assign err_timeout = err_to_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt   <= '0;
      err_to_q <= 1'b0;
    end else begin
      if ((state == S_WAIT) && !upd_done) wd_cnt <= wd_cnt + 1'b1;
      else wd_cnt <= '0;
      if (start_ok) err_to_q <= 1'b0;
      else if (timeout) err_to_q <= 1'b1;
    end
  end
`else
  assign timeout     = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_sica_seq_ctrl.sv
// Directed bench for sica_seq_ctrl with DIM=2, SAMPLES=8, MAX_ITERATIONS=3.
module tb_sica_seq_ctrl;
  localparam int DW = 32, SAMPLES = 8, DIM = 2, MAXIT = 3, LOGM = 3;
  localparam int AW = 4, CW = 1, IW = 2;
  localparam int W = AW + DW;

  logic clk = 1'b0, rst = 1'b1;
  logic load_data = 1'b0, serial_z_valid = 1'b0, sica_start = 1'b0;
  logic [DW-1:0] serial_z_in = '0;
  logic mem_we, rd_en, acc_clear, upd_start, load_full, sica_busy, sica_complete;
  logic err_overrun, err_timeout;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic [LOGM-1:0] rd_sample;
  logic [CW-1:0] comp_idx;
  logic [IW-1:0] iter_count;
  logic [2:0] state_dbg;
  logic upd_done, converged;
  logic resp_done = 1'b0, resp_c = 1'b0, resp_conv = 1'b0;
  logic inj_done = 1'b0, inj_conv = 1'b0;

  int total = 0, bad = 0;
  int rd_cycles = 0, upd_pulses = 0, clr_pulses = 0, seq_err = 0, run_err = 0, exp_rs = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];

  assign upd_done  = resp_done | inj_done;
  assign converged = resp_done ? resp_c : inj_conv;

  sica_seq_ctrl #(.DATA_WIDTH(DW), .SAMPLES(SAMPLES), .DIM(DIM),
                  .MAX_ITERATIONS(MAXIT), .LOGM(LOGM)) dut (
    .clk(clk), .reset(rst), .load_data(load_data), .serial_z_valid(serial_z_valid),
    .serial_z_in(serial_z_in), .sica_start(sica_start), .mem_we(mem_we),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .rd_en(rd_en), .rd_sample(rd_sample),
    .comp_idx(comp_idx), .acc_clear(acc_clear), .upd_start(upd_start),
    .upd_done(upd_done), .converged(converged), .iter_count(iter_count),
    .load_full(load_full), .sica_busy(sica_busy), .sica_complete(sica_complete),
    .err_overrun(err_overrun), .err_timeout(err_timeout), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "simulation did not terminate");
  end

  // observation: captured writes, read sweep shape, strobe counts
  always @(negedge clk) begin
    if (mem_we === 1'b1) got_q.push_back({mem_waddr, mem_wdata});
    if (rd_en === 1'b1) begin
      if (rd_sample !== LOGM'(exp_rs)) seq_err++;
      exp_rs++;
      rd_cycles++;
    end else begin
      if (exp_rs != 0 && exp_rs != SAMPLES) run_err++;
      exp_rs = 0;
    end
    if (upd_start === 1'b1) upd_pulses++;
    if (acc_clear === 1'b1) clr_pulses++;
  end

  // datapath model: upd_done two cycles after upd_start
  always @(negedge clk) begin
    if (upd_start === 1'b1 && !rst) begin
      @(negedge clk);
      @(negedge clk);
      resp_done = 1'b1;
      resp_c    = resp_conv;
      @(negedge clk);
      resp_done = 1'b0;
      resp_c    = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_words(input int base, input int n, input bit drop);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == n-1) check("not_full_early", load_full, 1'b0);
      load_data = 1'b1;
      serial_z_valid = 1'b1;
      serial_z_in = DW'(base + i);
      exp_q.push_back({AW'(i), DW'(base + i)});
    end
    @(negedge clk);
    serial_z_valid = 1'b0;
    if (drop) load_data = 1'b0;
  endtask

  task automatic drain_writes(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) check(tag, got_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, input string tag);
    int n = 0;
    while (state_dbg !== st && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_in_time"}, (n < budget), 1'b1);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    sica_start = 1'b1;
    @(negedge clk);
    sica_start = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_we"}, mem_we, 1'b0);
    check({tag, "_waddr_wdata"}, {mem_waddr, mem_wdata}, '0);
    check({tag, "_rd"}, {rd_en, rd_sample}, '0);
    check({tag, "_strobes"}, {acc_clear, upd_start}, '0);
    check({tag, "_idx_iter"}, {comp_idx, iter_count}, '0);
    check({tag, "_flags"}, {load_full, sica_busy, sica_complete, err_overrun, err_timeout}, '0);
  endtask

  initial begin
    int r0, u0, c0, s0, e0, n;
    // reset state
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // 1: full load 100..115
    load_words(100, 16, 1'b0);
    check("load_full_after16", load_full, 1'b1);
    check("no_overrun_after16", err_overrun, 1'b0);
    @(negedge clk);
    drain_writes("load1_wr");

    // 2: 17th word overruns, no write
    serial_z_valid = 1'b1;
    serial_z_in = 32'd999;
    @(negedge clk);
    serial_z_valid = 1'b0;
    check("overrun_set", err_overrun, 1'b1);
    check("full_kept", load_full, 1'b1);
    @(negedge clk);
    drain_writes("overrun_wr");

    // 3: partial load of 5 then start is refused
    load_data = 1'b0;
    load_words(200, 5, 1'b1);
    @(negedge clk);
    drain_writes("partial_wr");
    pulse_start();
    check("partial_not_full", load_full, 1'b0);
    check("partial_overrun_clr", err_overrun, 1'b0);
    check("partial_not_busy", sica_busy, 1'b0);
    repeat (2) @(negedge clk);
    check("partial_idle", {sica_busy, acc_clear, state_dbg}, '0);

    // 4: never converges, MAX_ITERATIONS per component
    resp_conv = 1'b0;
    load_words(300, 16, 1'b1);
    @(negedge clk);
    drain_writes("load4_wr");
    check("load4_full", load_full, 1'b1);
    r0 = rd_cycles; u0 = upd_pulses; c0 = clr_pulses; s0 = seq_err; e0 = run_err;
    pulse_start();
    check("s4_busy", sica_busy, 1'b1);
    check("s4_acc_clear", acc_clear, 1'b1);
    check("s4_not_complete", sica_complete, 1'b0);
    for (int i = 0; i < SAMPLES; i++) begin
      @(negedge clk);
      check("s4_sweep_rd", {rd_en, rd_sample}, {1'b1, LOGM'(i)});
      inj_done = (i == 3);
      inj_conv = (i == 3);
    end
    @(negedge clk);
    check("s4_upd_start", {upd_start, rd_en}, 2'b10);
    wait_state(3'd5, 200, "s4_next0");
    check("s4_comp0_iters", {comp_idx, iter_count}, {1'b0, 2'd3});
    wait_state(3'd6, 200, "s4_done");
    check("s4_final_idx_iter", {comp_idx, iter_count}, {1'b1, 2'd3});
    check("s4_complete", {sica_complete, sica_busy}, 2'b10);
    check("s4_rd_cycles", rd_cycles - r0, 48);
    check("s4_upd_pulses", upd_pulses - u0, 6);
    check("s4_clr_pulses", clr_pulses - c0, 6);
    check("s4_rd_sequence", (seq_err - s0) + (run_err - e0), 0);

    // 5: converges on first update, reloaded from DONE
    resp_conv = 1'b1;
    load_words(400, 16, 1'b1);
    @(negedge clk);
    drain_writes("load5_wr");
    r0 = rd_cycles; u0 = upd_pulses;
    pulse_start();
    check("s5_complete_cleared", sica_complete, 1'b0);
    check("s5_idx_iter_cleared", {comp_idx, iter_count}, '0);
    wait_state(3'd6, 200, "s5_done");
    check("s5_final_idx_iter", {comp_idx, iter_count}, {1'b1, 2'd1});
    check("s5_complete", sica_complete, 1'b1);
    check("s5_upd_pulses", upd_pulses - u0, 2);
    check("s5_rd_cycles", rd_cycles - r0, 16);

    // 6: asynchronous reset mid-sweep
    pulse_start();
    n = 0;
    while (!(rd_en === 1'b1 && rd_sample === 3'd4) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("s6_reach_rd4_in_time", (n < 50), 1'b1);
    rst = 1'b1;
    #1;
    check_zero("s6_reset");
    @(negedge clk);
    rst = 1'b0;
    pulse_start();
    check("s6_start_refused", {sica_busy, load_full}, 2'b00);
    @(negedge clk);
    check("s6_still_idle", {sica_busy, state_dbg}, '0);
    load_words(500, 16, 1'b1);
    @(negedge clk);
    drain_writes("load6_wr");
    pulse_start();
    check("s6_start_after_reload", sica_busy, 1'b1);
    wait_state(3'd6, 200, "s6_done");
    check("s6_complete", {sica_complete, err_timeout}, 2'b10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
